// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   state_t        : sequencer states
//   seq_out_t      : registered output bundle {pll_rst, sys_rst, ready, fault}
//   RELOCK_W       : width of the saturating lock-loss counter
//   cnt_width()    : cycle counter width for the three timing parameters
//   decode_outputs : output values for a given state
package pll_seq_pkg;

    localparam int unsigned RELOCK_W = 8;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    typedef struct packed {
        logic pll_rst;
        logic sys_rst;
        logic ready;
        logic fault;
    } seq_out_t;

    // One spare bit above clog2 of the largest count so no compare can wrap.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return w + 1;
    endfunction

    // Unknown encodings decode like RESET_PLL (everything held in reset).
    function automatic seq_out_t decode_outputs(input state_t s);
        seq_out_t o;
        o.pll_rst = 1'b1;
        o.sys_rst = 1'b1;
        o.ready   = 1'b0;
        o.fault   = 1'b0;
        case (s)
            WAIT_LOCK, STABILIZE: o.pll_rst = 1'b0;
            RUN: begin
                o.pll_rst = 1'b0;
                o.sys_rst = 1'b0;
                o.ready   = 1'b1;
            end
            FAULT:   o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and status signals of the reset sequencer.
//   pll_locked   : PLL lock (asynchronous)       -> sequencer
//   soft_restart : single-cycle restart request  -> sequencer
//   pll_rst, sys_rst, ready, fault, relock_count : sequencer ->
// modport master: the sequencer; modport slave: the surrounding logic.
interface pll_reset_sequencer_if;
    import pll_seq_pkg::*;

    logic                pll_locked;
    logic                soft_restart;
    logic                pll_rst;
    logic                sys_rst;
    logic                ready;
    logic                fault;
    logic [RELOCK_W-1:0] relock_count;

    modport master (
        input  pll_locked, soft_restart,
        output pll_rst, sys_rst, ready, fault, relock_count
    );

    modport slave (
        output pll_locked, soft_restart,
        input  pll_rst, sys_rst, ready, fault, relock_count
    );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-high reset.
//   clk : destination clock
//   rst : synchronous reset, clears both flops
//   d   : asynchronous input
//   q   : synchronised output (2-cycle latency)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock-recovery sequencer, clocked from the board refclk.
// Pulses the PLL reset, waits for lock, requires lock to stay stable before
// releasing the system reset, retries on lock timeout, counts lock losses in
// RUN and latches FAULT after MAX_RETRIES consecutive timeouts.
//   refclk : reference clock (only clock)
//   rst    : synchronous active-high reset
//   bus    : pll_locked/soft_restart in; pll_rst, sys_rst, ready, fault,
//            relock_count out (all outputs registered)
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_reset_sequencer_if.master bus
);
    import pll_seq_pkg::*;

    localparam int unsigned CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                           LOCK_STABLE_CYCLES);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);

    logic                locked_s;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    seq_out_t            out_q;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        if (bus.soft_restart) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABILIZE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_q + 1'b1;
                        cnt_d   = '0;
                        state_d = (retry_q == RETRY_LAST) ? FAULT : RESET_PLL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABILIZE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        if (relock_q != '1) relock_d = relock_q + 1'b1;
                        state_d = RESET_PLL;
                        cnt_d   = '0;
                    end
                end
                FAULT: ;
                default: begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= RESET_PLL;
            cnt_q    <= '0;
            retry_q  <= '0;
            relock_q <= '0;
            out_q    <= decode_outputs(RESET_PLL);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            relock_q <= relock_d;
            out_q    <= decode_outputs(state_d);
        end
    end

    assign bus.pll_rst      = out_q.pll_rst;
    assign bus.sys_rst      = out_q.sys_rst;
    assign bus.ready        = out_q.ready;
    assign bus.fault        = out_q.fault;
    assign bus.relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: table-driven power-up / lock-loss vectors,
// hand-written multi-cycle corner sequences and random lock activity, all
// also compared every cycle against a deadline-based behavioural model.
module tb_pll_reset_sequencer;

    localparam int P_RST = 4;
    localparam int P_TO  = 100;
    localparam int P_ST  = 8;
    localparam int P_MR  = 2;

    logic refclk = 1'b0;
    logic rst_i  = 1'b1;
    logic lk_i   = 1'b0;
    logic soft_i = 1'b0;

    int checks = 0;
    int passed = 0;

    always #5 refclk = ~refclk;

    pll_reset_sequencer_if bus ();
    assign bus.pll_locked   = lk_i;
    assign bus.soft_restart = soft_i;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (P_RST),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .LOCK_STABLE_CYCLES  (P_ST),
        .MAX_RETRIES         (P_MR)
    ) dut (
        .refclk (refclk),
        .rst    (rst_i),
        .bus    (bus)
    );

    // ---------------- behavioural model ----------------
    // Each phase is entered with an absolute deadline (edge number); the
    // lock input reaches the decision logic two edges after it is sampled.
    typedef enum int {M_RST, M_WAIT, M_STAB, M_RUN, M_FAULT} mphase_t;
    mphase_t m_phase    = M_RST;
    int      m_now      = 0;
    int      m_deadline = 0;
    int      m_retries  = 0;
    int      m_losses   = 0;
    logic    m_hist[2]  = '{1'b0, 1'b0};

    task automatic m_enter(input mphase_t p, input int n);
        m_phase    = p;
        m_deadline = m_now + n;
    endtask

    task automatic model_step(input logic r, input logic s, input logic lk);
        logic seen;
        m_now++;
        seen      = m_hist[0];
        m_hist[0] = m_hist[1];
        m_hist[1] = lk;
        if (r) begin
            m_hist[0] = 1'b0;
            m_hist[1] = 1'b0;
            m_enter(M_RST, P_RST);
            m_retries = 0;
            m_losses  = 0;
        end else if (s) begin
            m_enter(M_RST, P_RST);
            m_retries = 0;
        end else begin
            case (m_phase)
                M_RST: if (m_now == m_deadline) m_enter(M_WAIT, P_TO);
                M_WAIT: begin
                    if (seen) m_enter(M_STAB, P_ST);
                    else if (m_now == m_deadline) begin
                        m_retries++;
                        if (m_retries == P_MR) m_phase = M_FAULT;
                        else m_enter(M_RST, P_RST);
                    end
                end
                M_STAB: begin
                    if (!seen) m_enter(M_WAIT, P_TO);
                    else if (m_now == m_deadline) begin
                        m_phase   = M_RUN;
                        m_retries = 0;
                    end
                end
                M_RUN: begin
                    if (!seen) begin
                        if (m_losses < 255) m_losses++;
                        m_enter(M_RST, P_RST);
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [11:0] model_expect();
        logic [3:0] o;
        case (m_phase)
            M_RST:          o = 4'b1100;
            M_WAIT, M_STAB: o = 4'b0100;
            M_RUN:          o = 4'b0010;
            default:        o = 4'b1101;
        endcase
        return {o, 8'(m_losses)};
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [11:0] dut_outs();
        return {bus.pll_rst, bus.sys_rst, bus.ready, bus.fault, bus.relock_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step(rst_i, soft_i, lk_i);
        #1;
        check("model", 32'(dut_outs()), 32'(model_expect()));
    endtask

    // Expected value bits: {pll_rst, sys_rst, ready, fault}, checked every cycle.
    task automatic hold(input string name, input int n, input logic [3:0] exp,
                        input logic [7:0] rc);
        for (int k = 0; k < n; k++) begin
            tick();
            check(name, 32'(dut_outs()), 32'({exp, rc}));
        end
    endtask

    task automatic wait_ready(input string name, input int budget);
        int k = 0;
        while (bus.ready !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(bus.ready), 32'd1);
    endtask

    typedef struct {
        logic       rst;
        logic       lk;
        int         n;
        logic [3:0] exp;
        logic [7:0] rc;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t vt[$];
        int   run_left;

        // Power-up, then a single lock loss in RUN and the full re-sequence.
        vt.push_back('{1'b1, 1'b0,  3, 4'b1100, 8'd0});
        vt.push_back('{1'b0, 1'b0,  3, 4'b1100, 8'd0});
        vt.push_back('{1'b0, 1'b0,  1, 4'b0100, 8'd0});
        vt.push_back('{1'b0, 1'b0, 10, 4'b0100, 8'd0});
        vt.push_back('{1'b0, 1'b1, 10, 4'b0100, 8'd0});
        vt.push_back('{1'b0, 1'b1,  1, 4'b0010, 8'd0});
        vt.push_back('{1'b0, 1'b0,  1, 4'b0010, 8'd0});
        vt.push_back('{1'b0, 1'b1,  1, 4'b0010, 8'd0});
        vt.push_back('{1'b0, 1'b1,  1, 4'b1100, 8'd1});
        vt.push_back('{1'b0, 1'b1,  3, 4'b1100, 8'd1});
        vt.push_back('{1'b0, 1'b1,  1, 4'b0100, 8'd1});
        vt.push_back('{1'b0, 1'b1,  8, 4'b0100, 8'd1});
        vt.push_back('{1'b0, 1'b1,  1, 4'b0010, 8'd1});

        for (int i = 0; i < vt.size(); i++) begin
            rst_i = vt[i].rst;
            lk_i  = vt[i].lk;
            for (int k = 0; k < vt[i].n; k++) tick();
            check($sformatf("vec%0d", i), 32'(dut_outs()), 32'({vt[i].exp, vt[i].rc}));
        end

        // Lock glitch during STABILIZE (stable count 5): back to WAIT_LOCK.
        soft_i = 1'b1; lk_i = 1'b0;
        hold("glitch_restart", 1, 4'b1100, 8'd1);
        soft_i = 1'b0;
        hold("glitch_pllrst", 3, 4'b1100, 8'd1);
        hold("glitch_wait", 1, 4'b0100, 8'd1);
        lk_i = 1'b1;
        hold("glitch_stab", 6, 4'b0100, 8'd1);
        lk_i = 1'b0;
        hold("glitch_drop", 3, 4'b0100, 8'd1);
        lk_i = 1'b1;
        hold("glitch_relock", 10, 4'b0100, 8'd1);
        hold("glitch_ready", 1, 4'b0010, 8'd1);

        // Two lock timeouts, then FAULT held.
        soft_i = 1'b1; lk_i = 1'b0;
        hold("to_restart", 1, 4'b1100, 8'd1);
        soft_i = 1'b0;
        hold("to_pulse1", 3, 4'b1100, 8'd1);
        hold("to_wait1", 1, 4'b0100, 8'd1);
        hold("to_wait1", 99, 4'b0100, 8'd1);
        hold("to_retry", 1, 4'b1100, 8'd1);
        hold("to_pulse2", 3, 4'b1100, 8'd1);
        hold("to_wait2", 1, 4'b0100, 8'd1);
        hold("to_wait2", 99, 4'b0100, 8'd1);
        hold("to_fault", 1, 4'b1101, 8'd1);
        hold("fault_hold", 40, 4'b1101, 8'd1);

        // soft_restart out of FAULT.
        soft_i = 1'b1;
        hold("fault_exit", 1, 4'b1100, 8'd1);
        soft_i = 1'b0;
        hold("fault_pulse", 3, 4'b1100, 8'd1);
        hold("fault_wait", 1, 4'b0100, 8'd1);

        // soft_restart in RUN on the same edge the lock drop is seen.
        lk_i = 1'b1;
        hold("coin_lock", 10, 4'b0100, 8'd1);
        hold("coin_run", 1, 4'b0010, 8'd1);
        lk_i = 1'b0;
        hold("coin_sync", 2, 4'b0010, 8'd1);
        soft_i = 1'b1;
        hold("coin_restart", 1, 4'b1100, 8'd1);
        soft_i = 1'b0;
        lk_i   = 1'b1;

        // rst in the middle of STABILIZE.
        hold("mid_pulse", 3, 4'b1100, 8'd1);
        hold("mid_wait", 1, 4'b0100, 8'd1);
        hold("mid_stab", 3, 4'b0100, 8'd1);
        rst_i = 1'b1;
        hold("rst_mid_stab", 1, 4'b1100, 8'd0);
        rst_i = 1'b0;

        // 256 lock losses: relock_count saturates at 255.
        for (int i = 0; i < 256; i++) begin
            wait_ready("loss_ready", 200);
            if (i == 255) check("relock_255", 32'(bus.relock_count), 32'd255);
            lk_i = 1'b0;
            tick();
            lk_i = 1'b1;
            tick();
            tick();
        end
        wait_ready("sat_ready", 200);
        check("relock_sat", 32'(bus.relock_count), 32'd255);

        // Random lock activity with occasional soft_restart / rst.
        run_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                lk_i = ~lk_i;
                if (lk_i) run_left = int'($urandom_range(5, 60));
                else if ($urandom_range(0, 7) == 0) run_left = int'($urandom_range(100, 240));
                else run_left = int'($urandom_range(1, 12));
            end
            run_left--;
            soft_i = ($urandom_range(0, 299) == 0);
            rst_i  = ($urandom_range(0, 1499) == 0);
            tick();
        end
        soft_i = 1'b0;
        rst_i  = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
